// File: rtl/wb_master_pkg.sv
// Shared types and default parameters for the Wishbone command master.
package wb_master_pkg;

    // Default number of retry terminations tolerated before giving up.
    localparam int unsigned DEF_MAX_RETRY = 3;
    // Default number of BUS-state cycles allowed without any termination.
    localparam int unsigned DEF_TIMEOUT   = 64;

    // Counter widths sized for the legal parameter ranges (1..15 and 2..255).
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned WAIT_W  = 8;

    // Transaction sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Response status encodings returned with every response.
    typedef enum logic [1:0] {
        STAT_OK  = 2'b00,
        STAT_ERR = 2'b01,
        STAT_RTY = 2'b10,
        STAT_TMO = 2'b11
    } status_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-command Wishbone classic master: accepts one command, runs the bus
// cycle with retry and timeout handling, then holds the response until it is
// consumed.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic [1:0]  rsp_status,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    input  logic        ERR_I,
    input  logic        RTY_I
);

    state_t              state_q, state_d;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                we_q;
    logic [31:0]         adr_q;
    logic [31:0]         dat_q;
    logic [3:0]          sel_q;
    logic [31:0]         rsp_dat_q;
    status_t             status_q;

    // Terminations only count while the bus cycle is live; priority ERR > RTY > ACK.
    logic in_bus, t_err, t_rty, t_ack, retry_ok, timeout_hit;
    assign in_bus      = (state_q == ST_BUS);
    assign t_err       = in_bus & ERR_I;
    assign t_rty       = in_bus & ~ERR_I & RTY_I;
    assign t_ack       = in_bus & ~ERR_I & ~RTY_I & ACK_I;
    assign retry_ok    = (retry_cnt < RETRY_W'(MAX_RETRY));
    // A termination in the final wait cycle takes precedence over the timeout.
    assign timeout_hit = in_bus & ~(ERR_I | RTY_I | ACK_I)
                         & (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // State register with synchronous reset back to IDLE.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_BUS;
            ST_BUS: begin
                if (t_err || t_ack)  state_d = ST_RESP;
                else if (t_rty)      state_d = retry_ok ? ST_GAP : ST_RESP;
                else if (timeout_hit) state_d = ST_RESP;
            end
            ST_GAP:  state_d = ST_BUS;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and bus-strobe outputs decoded from the current state.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE) & ~rst;
        rsp_valid = (state_q == ST_RESP);
        CYC_O     = in_bus;
        STB_O     = in_bus;
    end

    // Command capture, retry/wait counters and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            retry_cnt <= '0;
            wait_cnt  <= '0;
            rsp_dat_q <= '0;
            status_q  <= STAT_OK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        we_q      <= cmd_we;
                        adr_q     <= cmd_adr;
                        dat_q     <= cmd_dat;
                        sel_q     <= cmd_sel;
                        retry_cnt <= '0;
                        wait_cnt  <= '0;
                    end
                end
                ST_BUS: begin
                    if (t_err) begin
                        status_q  <= STAT_ERR;
                        rsp_dat_q <= '0;
                    end else if (t_rty) begin
                        if (retry_ok) begin
                            retry_cnt <= retry_cnt + 1'b1;
                        end else begin
                            status_q  <= STAT_RTY;
                            rsp_dat_q <= '0;
                        end
                    end else if (t_ack) begin
                        status_q  <= STAT_OK;
                        rsp_dat_q <= we_q ? 32'h0 : DAT_I;
                    end else if (timeout_hit) begin
                        status_q  <= STAT_TMO;
                        rsp_dat_q <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // Re-entry into BUS restarts the timeout window.
                ST_GAP:  wait_cnt <= '0;
                default: ;
            endcase
        end
    end

    assign WE_O       = we_q;
    assign ADR_O      = adr_q;
    assign DAT_O      = dat_q;
    assign SEL_O      = sel_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = status_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master with default parameters.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic [31:0] DAT_I;
    logic        ACK_I, ERR_I, RTY_I;

    int n_cmp = 0;
    int n_bad = 0;

    wb_cmd_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_status(rsp_status),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O),
        .DAT_O(DAT_O), .SEL_O(SEL_O), .DAT_I(DAT_I),
        .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command for a single edge (DUT assumed idle).
    task automatic issue_cmd(input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Consume the pending response.
    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({cmd_ready, rsp_valid, CYC_O, STB_O, WE_O} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 00000", {cmd_ready, rsp_valid, CYC_O, STB_O, WE_O});
        end
        n_cmp++;
        if ({ADR_O, DAT_O, SEL_O, rsp_dat, rsp_status} !== 102'b0) begin
            n_bad++;
            $display("FAIL reset_data: adr=%h dat=%h sel=%h rdat=%h st=%b expected all 0",
                     ADR_O, DAT_O, SEL_O, rsp_dat, rsp_status);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_read_ack();
        issue_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        n_cmp++;
        if ({CYC_O, STB_O, WE_O, ADR_O, SEL_O, cmd_ready, rsp_valid} !== {3'b110, 32'h100, 4'hF, 2'b00}) begin
            n_bad++;
            $display("FAIL read_bus: cyc=%b stb=%b we=%b adr=%h sel=%h rdy=%b rv=%b expected 1 1 0 00000100 f 0 0",
                     CYC_O, STB_O, WE_O, ADR_O, SEL_O, cmd_ready, rsp_valid);
        end
        ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
        tick();
        ACK_I = 1'b0; DAT_I = 32'h1111_1111;
        n_cmp++;
        if ({rsp_valid, CYC_O, rsp_dat, rsp_status} !== {2'b10, 32'hDEAD_BEEF, 2'b00}) begin
            n_bad++;
            $display("FAIL read_rsp: rv=%b cyc=%b dat=%h st=%b expected 1 0 deadbeef 00",
                     rsp_valid, CYC_O, rsp_dat, rsp_status);
        end
        release_rsp();
        n_cmp++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL read_done: rv=%b rdy=%b expected 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_write_retry();
        issue_cmd(1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3);
        DAT_I = 32'hCAFE_F00D;
        for (int r = 0; r < 2; r++) begin
            RTY_I = 1'b1;
            tick();
            RTY_I = 1'b0;
            n_cmp++;
            if ({CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, rsp_valid} !== {3'b001, 32'h200, 32'h1234_5678, 4'h3, 1'b0}) begin
                n_bad++;
                $display("FAIL retry_gap%0d: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rv=%b expected 0 0 1 00000200 12345678 3 0",
                         r, CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, rsp_valid);
            end
            tick();
            n_cmp++;
            if ({CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O} !== {3'b111, 32'h200, 32'h1234_5678, 4'h3}) begin
                n_bad++;
                $display("FAIL retry_bus%0d: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h expected 1 1 1 00000200 12345678 3",
                         r, CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O);
            end
        end
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_dat, rsp_status} !== {1'b1, 32'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL write_rsp: rv=%b dat=%h st=%b expected 1 00000000 00", rsp_valid, rsp_dat, rsp_status);
        end
        release_rsp();
    endtask

    task automatic test_retry_exhaust();
        int cyc_cnt = 0;
        int phases = 0;
        logic prev = 1'b0;
        logic done = 1'b0;
        issue_cmd(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        RTY_I = 1'b1; DAT_I = 32'h5555_AAAA;
        for (int i = 0; i < 50 && !done; i++) begin
            if (CYC_O) cyc_cnt++;
            if (CYC_O && !prev) phases++;
            prev = CYC_O;
            if (rsp_valid) done = 1'b1;
            else tick();
        end
        RTY_I = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL rty_wait: no response within 50 cycles");
        end
        n_cmp++;
        if (phases !== 4 || cyc_cnt !== 4) begin
            n_bad++;
            $display("FAIL rty_phases: phases=%0d cyc_cycles=%0d expected 4 4", phases, cyc_cnt);
        end
        n_cmp++;
        if ({rsp_status, rsp_dat} !== {2'b10, 32'h0}) begin
            n_bad++;
            $display("FAIL rty_status: st=%b dat=%h expected 10 00000000", rsp_status, rsp_dat);
        end
        release_rsp();
    endtask

    task automatic test_timeout();
        int cyc_cnt = 0;
        logic done = 1'b0;
        issue_cmd(1'b0, 32'h0000_0400, 32'h0, 4'hF);
        DAT_I = 32'h7777_7777;
        for (int i = 0; i < 200 && !done; i++) begin
            if (CYC_O) cyc_cnt++;
            if (rsp_valid) done = 1'b1;
            else tick();
        end
        n_cmp++;
        if (done !== 1'b1 || cyc_cnt !== 64) begin
            n_bad++;
            $display("FAIL tmo_len: done=%b cyc_cycles=%0d expected 1 64", done, cyc_cnt);
        end
        n_cmp++;
        if ({rsp_status, rsp_dat} !== {2'b11, 32'h0}) begin
            n_bad++;
            $display("FAIL tmo_status: st=%b dat=%h expected 11 00000000", rsp_status, rsp_dat);
        end
        release_rsp();
    endtask

    task automatic test_ack_beats_timeout();
        issue_cmd(1'b0, 32'h0000_0500, 32'h0, 4'hF);
        for (int i = 0; i < 63; i++) tick();
        n_cmp++;
        if (CYC_O !== 1'b1) begin
            n_bad++;
            $display("FAIL late_cyc: got %b expected 1 in 64th bus cycle", CYC_O);
        end
        ACK_I = 1'b1; DAT_I = 32'h0BAD_F00D;
        tick();
        ACK_I = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b00, 32'h0BAD_F00D}) begin
            n_bad++;
            $display("FAIL late_ack: rv=%b st=%b dat=%h expected 1 00 0badf00d", rsp_valid, rsp_status, rsp_dat);
        end
        release_rsp();
    endtask

    task automatic test_err_priority();
        issue_cmd(1'b0, 32'h0000_0600, 32'h0, 4'hF);
        ERR_I = 1'b1; ACK_I = 1'b1; DAT_I = 32'h1234_ABCD;
        tick();
        ERR_I = 1'b0; ACK_I = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b01, 32'h0}) begin
            n_bad++;
            $display("FAIL err_prio: rv=%b st=%b dat=%h expected 1 01 00000000", rsp_valid, rsp_status, rsp_dat);
        end
        release_rsp();
    endtask

    task automatic test_rsp_hold();
        logic ok = 1'b1;
        issue_cmd(1'b0, 32'h0000_0700, 32'h0, 4'hF);
        ACK_I = 1'b1; DAT_I = 32'hA5A5_5A5A;
        tick();
        // Stray terminations and a new command must not disturb the held response.
        cmd_valid = 1'b1; ERR_I = 1'b1; DAT_I = 32'h0;
        for (int i = 0; i < 10; i++) begin
            if ({rsp_valid, cmd_ready, CYC_O, rsp_dat, rsp_status} !== {3'b100, 32'hA5A5_5A5A, 2'b00}) begin
                ok = 1'b0;
                $display("FAIL hold_c%0d: rv=%b rdy=%b cyc=%b dat=%h st=%b expected 1 0 0 a5a55a5a 00",
                         i, rsp_valid, cmd_ready, CYC_O, rsp_dat, rsp_status);
            end
            tick();
        end
        n_cmp++;
        if (ok !== 1'b1) n_bad++;
        cmd_valid = 1'b0; ACK_I = 1'b0; ERR_I = 1'b0;
        release_rsp();
        n_cmp++;
        if ({rsp_valid, cmd_ready, CYC_O} !== 3'b010) begin
            n_bad++;
            $display("FAIL hold_release: rv=%b rdy=%b cyc=%b expected 0 1 0", rsp_valid, cmd_ready, CYC_O);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int first = -1;
        int second = -1;
        cmd_valid = 1'b1; ACK_I = 1'b1; rsp_ready = 1'b1;
        cmd_we = 1'b0; cmd_adr = 32'h800; cmd_sel = 4'hF; DAT_I = 32'h42;
        for (int i = 0; i < 12; i++) begin
            if (cmd_ready) begin
                accepts++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            tick();
        end
        cmd_valid = 1'b0; ACK_I = 1'b0; rsp_ready = 1'b0;
        n_cmp++;
        if (accepts !== 4 || second - first !== 3) begin
            n_bad++;
            $display("FAIL b2b: accepts=%0d spacing=%0d expected 4 3", accepts, second - first);
        end
    endtask

    task automatic test_reset_mid_bus();
        issue_cmd(1'b1, 32'h0000_0900, 32'hFEED_FACE, 4'hC);
        rst = 1'b1; ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        n_cmp++;
        if ({CYC_O, STB_O, rsp_valid, cmd_ready, ADR_O} !== {4'b0000, 32'h0}) begin
            n_bad++;
            $display("FAIL rst_mid: cyc=%b stb=%b rv=%b rdy=%b adr=%h expected 0 0 0 0 00000000",
                     CYC_O, STB_O, rsp_valid, cmd_ready, ADR_O);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({CYC_O, rsp_valid, cmd_ready, rsp_status} !== 5'b00100) begin
            n_bad++;
            $display("FAIL rst_after: cyc=%b rv=%b rdy=%b st=%b expected 0 0 1 00",
                     CYC_O, rsp_valid, cmd_ready, rsp_status);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; DAT_I = '0; ACK_I = 1'b0; ERR_I = 1'b0;
        RTY_I = 1'b0;
        test_reset();
        test_read_ack();
        test_write_retry();
        test_retry_exhaust();
        test_timeout();
        test_ack_beats_timeout();
        test_err_priority();
        test_rsp_hold();
        test_back_to_back();
        test_reset_mid_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL expose these parameters, one per line:
- MAX_RETRY, default 3, RTY_I retries allowed before giving up (1..15).
- TIMEOUT, default 64, BUS-state cycles without termination before abort (2..255).

REQ-003 The block SHALL expose these ports, one per line:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte lane select
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_dat  out  32  read data
- rsp_status  out  2  00 OK, 01 ERR, 10 RTY exhausted, 11 timeout
- CYC_O  out  1  Wishbone cycle
- STB_O  out  1  Wishbone strobe
- WE_O  out  1  Wishbone write enable
- ADR_O  out  32  Wishbone address
- DAT_O  out  32  Wishbone write data
- SEL_O  out  4  Wishbone byte select
- DAT_I  in  32  Wishbone read data
- ACK_I  in  1  normal termination
- ERR_I  in  1  error termination
- RTY_I  in  1  retry termination

Function
REQ-004 The FSM SHALL have states IDLE, BUS, GAP and RESP.
REQ-005 In IDLE, cmd_ready SHALL be 1; in all other states it SHALL be 0.
REQ-006 In IDLE, a handshake SHALL register we/adr/dat/sel, clear the retry count and move to BUS.
REQ-007 CYC_O and STB_O SHALL be 1 exactly while in BUS; WE_O/ADR_O/DAT_O/SEL_O SHALL hold the registered command and stay stable throughout BUS and GAP.
REQ-008 In BUS, terminations SHALL be sampled each rising edge with priority ERR_I > RTY_I > ACK_I.
REQ-009 ACK_I in BUS SHALL set status OK, capture DAT_I into rsp_dat for reads (0 for writes) and move to RESP.
REQ-010 ERR_I in BUS SHALL set status ERR, set rsp_dat=0 and move to RESP.
REQ-011 RTY_I in BUS with retry count < MAX_RETRY SHALL increment the count and move to GAP.
REQ-012 RTY_I in BUS with retry count = MAX_RETRY SHALL set status 10, rsp_dat=0 and move to RESP.
REQ-013 GAP SHALL last exactly one cycle with CYC_O=STB_O=0, then return to BUS with identical attributes.
REQ-014 The wait counter SHALL clear on every entry to BUS and increment each BUS cycle without termination.
REQ-015 When the wait counter reaches TIMEOUT-1 with no termination, the block SHALL set status 11, rsp_dat=0 and move to RESP; a termination in that same cycle SHALL win over timeout.
REQ-016 In RESP, rsp_valid SHALL be 1 with rsp_dat/rsp_status held; on rsp_ready the block SHALL return to IDLE.
REQ-017 ACK_I/ERR_I/RTY_I outside BUS SHALL be ignored.
REQ-018 Latency: command accepted at edge N gives CYC_O high in cycle N+1; zero-wait ACK gives rsp_valid at N+2; minimum command-to-command spacing SHALL be 3 cycles.

Reset
REQ-019 While rst=1 at an edge, the state SHALL become IDLE and all outputs SHALL be 0, except cmd_ready, which SHALL become 1 after reset deasserts.
REQ-020 Reset mid-cycle SHALL drop CYC_O/STB_O at that edge, discard the command and any pending response, and clear all counters.

Structure
REQ-021 Package wb_master_pkg SHALL hold the state enum, status enum/encodings and default MAX_RETRY/TIMEOUT constants.
REQ-022 The block SHALL be a single module with no sub-module; counters and FSM SHALL be inline.

Verification
REQ-023 Read adr=0x100, ACK_I one cycle after CYC_O with DAT_I=0xDEADBEEF -> rsp_dat=0xDEADBEEF, status 00, rsp_valid 2 cycles after accept.
REQ-024 Write with RTY_I twice then ACK_I -> two one-cycle CYC_O drops, attributes unchanged, status 00.
REQ-025 RTY_I on every attempt, MAX_RETRY=3 -> exactly 4 BUS phases, status 10.
REQ-026 No termination, TIMEOUT=64 -> CYC_O high exactly 64 cycles, status 11; ERR_I+ACK_I together -> status 01.
REQ-027 rsp_ready held low 10 cycles -> rsp_valid/rsp_dat stable and cmd_ready 0 throughout; rst asserted mid-BUS -> CYC_O 0 next edge and no response.
